// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Desc     : Shared types for the instruction fetch request sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Response FIFO entry layout at the default 32-bit widths
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Desc     : Small FIFO with synchronous clear; depth need not be a power of 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_data
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
        end
    end

    // Storage needs no reset: the head is only meaningful when not empty
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_empty     = (r_count == '0);
    assign o_head_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_request_ctrl.sv
// ============================================================================
// Module   : fetch_request_ctrl
// Desc     : Issues fetch requests, tracks in-flight ones and buffers correct-path
//            responses for decode, discarding wrong-path responses on redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_request_ctrl
    import fetch_pkg::*;
#(
    parameter int size            = 32,
    parameter int INST_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [size-1:0]   pc_addr,
    output logic              bubble,
    input  logic              redirect,
    output logic              imem_req_valid,
    output logic [size-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [size-1:0]   inst_pc,
    input  logic              decode_ready
);

    localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_ent_w = size + INST_W;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_buffered;
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic [c_cnt_w-1:0] w_inflight_nxt;
    logic [c_cnt_w-1:0] w_buffered_nxt;
    logic [c_cnt_w-1:0] w_drop_nxt;
    logic [c_cnt_w:0]   w_occ_post;

    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_bubble;
    logic               w_rsp_keep;
    logic               w_clear;
    logic               w_consume;
    logic               w_inst_valid;
    logic               w_req_fifo_empty;
    logic               w_rsp_fifo_empty;
    logic [size-1:0]    w_req_head_pc;
    logic [c_ent_w-1:0] w_rsp_head;

    assign w_inst_valid = reset & ~w_rsp_fifo_empty;
    assign w_consume    = w_inst_valid & decode_ready;
    assign w_clear      = redirect & (r_state != START);
    assign w_rsp_keep   = (r_state == RUN) & imem_rsp_valid & ~redirect;
    assign w_req_fire   = w_req_valid & imem_req_ready;

    // Occupancy after this cycle's consume; independent of imem_rsp_*
    assign w_occ_post = {1'b0, r_inflight} + {1'b0, r_buffered}
                      - {{c_cnt_w{1'b0}}, w_consume};

    always_comb begin
        w_state_nxt    = r_state;
        w_req_valid    = 1'b0;
        w_bubble       = 1'b1;
        w_inflight_nxt = r_inflight;
        w_buffered_nxt = r_buffered;
        w_drop_nxt     = r_drop_cnt;
        case (r_state)
            START: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_req_valid = (w_occ_post < (c_cnt_w + 1)'(MAX_OUTSTANDING)) & ~redirect;
                w_bubble    = ~(w_req_valid & imem_req_ready) & ~redirect;
                if (redirect) begin
                    w_drop_nxt     = r_inflight - c_cnt_w'(imem_rsp_valid);
                    w_inflight_nxt = w_drop_nxt;
                    w_buffered_nxt = '0;
                    w_state_nxt    = (w_drop_nxt == '0) ? RUN : DRAIN;
                end else begin
                    w_inflight_nxt = r_inflight + c_cnt_w'(w_req_fire)
                                   - c_cnt_w'(imem_rsp_valid);
                    w_buffered_nxt = r_buffered + c_cnt_w'(imem_rsp_valid)
                                   - c_cnt_w'(w_consume);
                end
            end
            DRAIN: begin
                w_bubble       = ~redirect;
                w_drop_nxt     = r_drop_cnt - c_cnt_w'(imem_rsp_valid);
                w_inflight_nxt = w_drop_nxt;
                w_buffered_nxt = '0;
                w_state_nxt    = (w_drop_nxt == '0) ? RUN : DRAIN;
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= START;
            r_inflight <= '0;
            r_buffered <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            r_buffered <= w_buffered_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    fetch_fifo #(
        .WIDTH (size),
        .DEPTH (MAX_OUTSTANDING)
    ) u_req_pc_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_push      (w_req_fire),
        .i_push_data (pc_addr),
        .i_pop       (w_rsp_keep),
        .o_empty     (w_req_fifo_empty),
        .o_head_data (w_req_head_pc)
    );

    fetch_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_push      (w_rsp_keep),
        .i_push_data ({w_req_head_pc, imem_rsp_data}),
        .i_pop       (w_consume),
        .o_empty     (w_rsp_fifo_empty),
        .o_head_data (w_rsp_head)
    );

    // Every output is forced low while reset is held
    assign bubble         = reset & w_bubble;
    assign imem_req_valid = reset & w_req_valid & ~w_req_fifo_empty | reset & w_req_valid;
    assign imem_req_addr  = reset ? pc_addr : '0;
    assign inst_valid     = w_inst_valid;
    assign inst_pc        = w_inst_valid ? w_rsp_head[c_ent_w-1 -: size] : '0;
    assign inst_data      = w_inst_valid ? w_rsp_head[INST_W-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_request_ctrl.sv
// ============================================================================
// Module   : tb_fetch_request_ctrl
// Desc     : Randomized bench for fetch_request_ctrl with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_request_ctrl;

    localparam int c_max    = 2;
    localparam int c_cycles = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        bubble;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        decode_ready;

    always #5 clk = ~clk;

    fetch_request_ctrl #(
        .size            (32),
        .INST_W          (32),
        .MAX_OUTSTANDING (c_max)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .pc_addr        (pc_addr),
        .bubble         (bubble),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .decode_ready   (decode_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ref_entry_t;

    // Memory model and PC controller model
    mem_req_t    mem_q[$];
    logic [31:0] pc;
    int          s_lat;
    bit          s_flush;
    bit          s_prev_reset;

    // Reference model: start flag, drop count, pending PCs, buffered entries
    bit          ref_start;
    int          ref_drop;
    logic [31:0] ref_pend[$];
    ref_entry_t  ref_buf[$];

    logic        e_bubble;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst_pc;
    logic [31:0] e_inst_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp, input int cyc);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    endtask

    task automatic drive(input int cyc);
        bit in_reset;
        bit release_cyc;
        in_reset    = (cyc < 3) || (cyc >= 400 && cyc < 402);
        release_cyc = !in_reset && !s_prev_reset;
        reset       = !in_reset;
        if (cyc < 60) begin
            imem_req_ready = 1'b1; decode_ready = 1'b1; redirect = 1'b0; s_lat = 1;
        end else if (cyc < 100) begin
            imem_req_ready = 1'b1; decode_ready = (cyc >= 75); redirect = 1'b0; s_lat = 1;
        end else if (cyc < 130) begin
            imem_req_ready = !(cyc >= 100 && cyc < 103); decode_ready = 1'b1;
            redirect = 1'b0; s_lat = 1;
        end else if (cyc >= 300 && cyc < 400) begin
            imem_req_ready = 1'b1; decode_ready = 1'b1;
            redirect = (cyc % 7 == 0) || (cyc % 7 == 2); s_lat = 3;
        end else begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            decode_ready   = ($urandom_range(0, 9) < 7);
            redirect       = ($urandom_range(0, 11) == 0);
            s_lat          = $urandom_range(1, 3);
        end
        if (release_cyc || in_reset) redirect = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        s_flush        = 1'b0;
        if (mem_q.size() > 0 && (mem_q[0].due <= cyc || release_cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end
        if (release_cyc) s_flush = 1'b1;
        if (in_reset) begin
            ref_start = 1'b1;
            ref_drop  = 0;
            ref_pend.delete();
            ref_buf.delete();
        end
        s_prev_reset = in_reset;
        pc_addr      = pc;
    endtask

    task automatic predict();
        int occ;
        e_bubble = 1'b0; e_req_valid = 1'b0; e_req_addr = '0;
        e_inst_valid = 1'b0; e_inst_pc = '0; e_inst_data = '0;
        if (reset) begin
            e_req_addr   = pc;
            e_inst_valid = (ref_buf.size() > 0);
            if (e_inst_valid) begin
                e_inst_pc   = ref_buf[0].pc;
                e_inst_data = ref_buf[0].data;
            end
            if (ref_start) begin
                e_bubble = 1'b1;
            end else if (ref_drop > 0) begin
                e_bubble = !redirect;
            end else begin
                occ = ref_pend.size() + ref_buf.size() - ((e_inst_valid && decode_ready) ? 1 : 0);
                e_req_valid = (occ < c_max) && !redirect;
                e_bubble    = !(e_req_valid && imem_req_ready) && !redirect;
            end
        end
    endtask

    task automatic compare(input int cyc);
        check("bubble",     {63'd0, bubble},         {63'd0, e_bubble},     cyc);
        check("req_valid",  {63'd0, imem_req_valid}, {63'd0, e_req_valid},  cyc);
        check("req_addr",   {32'd0, imem_req_addr},  {32'd0, e_req_addr},   cyc);
        check("inst_valid", {63'd0, inst_valid},     {63'd0, e_inst_valid}, cyc);
        check("inst_pc",    {32'd0, inst_pc},        {32'd0, e_inst_pc},    cyc);
        check("inst_data",  {32'd0, inst_data},      {32'd0, e_inst_data},  cyc);
        // Fixed landmarks of the start-up sequence
        if (cyc == 3) check("start_bubble", {63'd0, bubble}, 64'd1, cyc);
        if (cyc == 4) check("first_req", {32'd0, imem_req_addr}, 64'h8000_0000, cyc);
        if (cyc == 6) check("first_inst", {32'd0, inst_pc}, 64'h8000_0000, cyc);
        if (cyc == 7) check("second_inst", {32'd0, inst_pc}, 64'h8000_0004, cyc);
    endtask

    task automatic update(input int cyc);
        ref_entry_t ent;
        mem_req_t   req;
        if (!reset) begin
            ref_start = 1'b1;
        end else if (ref_start) begin
            ref_start = 1'b0;
        end else if (redirect) begin
            ref_drop = ((ref_drop > 0) ? ref_drop : ref_pend.size()) - (imem_rsp_valid ? 1 : 0);
            ref_pend.delete();
            ref_buf.delete();
        end else if (ref_drop > 0) begin
            if (imem_rsp_valid) ref_drop--;
        end else begin
            if (e_inst_valid && decode_ready) void'(ref_buf.pop_front());
            if (imem_rsp_valid && ref_pend.size() > 0) begin
                ent.pc   = ref_pend.pop_front();
                ent.data = imem_rsp_data;
                ref_buf.push_back(ent);
            end
            if (e_req_valid && imem_req_ready) ref_pend.push_back(pc);
        end
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (s_flush) mem_q.delete();
        if (reset && e_req_valid && imem_req_ready) begin
            req.addr = pc;
            req.data = $urandom;
            req.due  = cyc + s_lat;
            mem_q.push_back(req);
        end
        if (!reset) pc = 32'h8000_0000;
        else if (redirect) pc = 32'h8000_0100 + ($urandom_range(0, 63) << 4);
        else if (!e_bubble) pc = pc + 32'd4;
    endtask

    initial begin
        reset = 1'b0; pc_addr = '0; redirect = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; decode_ready = 1'b0;
        pc = 32'h8000_0000; ref_start = 1'b1; ref_drop = 0;
        s_prev_reset = 1'b1; s_flush = 1'b0; s_lat = 1;
        for (int cyc = 0; cyc < c_cycles; cyc++) begin
            @(posedge clk);
            if (cyc > 0) update(cyc - 1);
            #1;
            drive(cyc);
            #1;
            predict();
            compare(cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_request_ctrl.md
# fetch_request_ctrl

Sequencer between `program_counter_ctrl` and the instruction-memory port. It issues one fetch request per accepted handshake and advances the PC only when the memory accepts the request. It tracks in-flight requests and buffers responses until decode takes them. On a redirect it discards every wrong-path response still in flight, so only correct-path instructions reach decode.

## Interface
Parameters:
- `size`, 32, address/PC width
- `INST_W`, 32, instruction width
- `MAX_OUTSTANDING`, 2, max requests issued-but-not-consumed (in flight + buffered); must be ≥1

Ports:
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `pc_addr`  in  size  current PC from PC controller
- `bubble`  out  1  to PC controller `buble`; 1 = hold PC
- `redirect`  in  1  misprediction or taken jump; PC controller loads the new PC this cycle
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  size  fetch address (= `pc_addr`)
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response valid; in request order; cannot be back-pressured
- `imem_rsp_data`  in  INST_W  instruction word
- `inst_valid`  out  1  instruction available to decode
- `inst_data`  out  INST_W  instruction
- `inst_pc`  out  size  PC of `inst_data`
- `decode_ready`  in  1  decode consumes the instruction when `inst_valid & decode_ready`

## Operation
- Counters:
  - `inflight`: issued, no response yet.
  - `buffered`: responses held for decode.
  - Both are `$clog2(MAX_OUTSTANDING+1)` bits.
  - `inflight + buffered` never exceeds `MAX_OUTSTANDING`.
- Request PC FIFO (depth `MAX_OUTSTANDING`): the PC is pushed on request handshake and popped on a kept response.
- Response FIFO (depth `MAX_OUTSTANDING`): holds `{pc,data}`. Its head drives `inst_valid`, `inst_pc` and `inst_data`.
- FSM states:
  - `START`: entered on reset; lasts 1 cycle; no request; `bubble=1`. Next state is `RUN`.
  - `RUN`:
    - `imem_req_valid = (inflight+buffered < MAX_OUTSTANDING) & ~redirect`.
    - `bubble = ~(imem_req_valid & imem_req_ready) & ~redirect`.
    - A consume in the same cycle frees a slot for a request (use the post-consume count).
  - `DRAIN`:
    - `drop_cnt` > 0; no requests.
    - `bubble = ~redirect`.
    - Each `imem_rsp_valid` decrements `drop_cnt`, and the data is discarded.
    - Go to `RUN` when `drop_cnt` reaches 0.
- Redirect (any state except `START`):
  - `bubble=0` so the PC loads the new value.
  - No request that cycle.
  - Response FIFO and request PC FIFO are cleared; `inst_valid` drops next cycle.
  - `drop_cnt <= inflight - imem_rsp_valid`. A response arriving in the redirect cycle is dropped.
  - If the result is 0, go to `RUN`; otherwise go to `DRAIN`. `inflight` follows `drop_cnt`.
- Redirect inside `DRAIN`: `drop_cnt` continues to decrement; stay in `DRAIN`.
- Response in `RUN`:
  - Push `{popped pc, imem_rsp_data}` into the response FIFO.
  - Space is guaranteed by the occupancy rule.
- Simultaneous push and consume on the response FIFO: both take effect; `buffered` is unchanged.

## Timing
- All outputs are 0 during reset; state becomes `START`; all counters and FIFOs are empty.
- `imem_req_addr = pc_addr` combinationally; the PC advances on the edge after a handshake.
- Response-to-`inst_valid` latency: 1 cycle (registered FIFO). Back-to-back responses sustain 1 instruction/cycle when `decode_ready=1`.
- Redirect-to-first new request: the cycle after redirect when `drop_cnt=0`. Otherwise it is the cycle after the last dropped response.
- No combinational path from `imem_rsp_*` to `imem_req_valid`.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t {START, RUN, DRAIN}` and a `fetch_entry_t` struct `{pc, data}`.
- One sub-module: `fetch_fifo`.
  - Parameterized width/depth; synchronous clear; power-of-two depth not required.
  - Instantiated twice (request PC FIFO, response FIFO).

## Test plan
- **Reset and start:** release `reset`; memory always ready, 1-cycle response. First request is at 0x80000000 in the cycle after `START`. Decode then sees PCs 0x80000000, 0x80000004, ... one per cycle.
- **Backpressure:** hold `decode_ready=0` with `MAX_OUTSTANDING=2`. Exactly 2 requests issue; `bubble` stays 1 and the PC holds. Release: the third request issues in the same cycle as the first consume.
- **Memory not ready:** `imem_req_ready=0` for 3 cycles. `bubble=1` and `imem_req_addr` is stable; on ready, the PC advances by 4.
- **Redirect with 2 in flight:** redirect to 0x80000100. Both old responses are dropped (`inst_valid` stays 0). The next request is at 0x80000100 after the second drop.
- **Redirect with simultaneous response:** `drop_cnt = inflight-1`; that response never reaches decode. A second redirect during `DRAIN` leaves only the latest target fetched.
- **Reset mid-operation:** assert `reset` with 2 in flight. All outputs go to 0 immediately; late responses after release are ignored in `START`.
